// File: rtl/clock_set_pkg.sv
// clock_set_pkg: set-mode states, default timing constants and state sequencing
package clock_set_pkg;
    typedef enum logic [2:0] {RUN, SET_CUR_H, SET_CUR_M, SET_ALM_H, SET_ALM_M} set_state_e;
    localparam int HOLD_MS_DEF = 500;
    localparam int REPEAT_MS_DEF = 150;
    localparam int TIMEOUT_MS_DEF = 10000;
    localparam int BLINK_MS_DEF = 250;
    function automatic set_state_e next_state(input set_state_e s);
        return s == SET_ALM_M ? RUN : set_state_e'(s + 3'd1);
    endfunction
endpackage

// File: rtl/btn_repeat.sv
// btn_repeat: rising-edge pulse with press-and-hold auto-repeat, disarmed until release after a clear
module btn_repeat #(
    parameter int HOLD = 500,
    parameter int REPEAT = 150
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_ms,
    input  logic level,
    input  logic enable,
    input  logic clear,
    output logic pulse,
    output logic activity
);
    localparam int W = $clog2((HOLD > REPEAT ? HOLD : REPEAT) + 1);
    localparam logic [W-1:0] HOLD_LAST = W'(HOLD - 1);
    localparam logic [W-1:0] REPEAT_LAST = W'(REPEAT - 1);
    logic prev, armed, rep, hit;
    logic [W-1:0] cnt;
    always_comb begin
        activity = enable & level & armed;
        hit = tick_ms & (cnt == (rep ? REPEAT_LAST : HOLD_LAST));
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= 1'b0;
            armed <= 1'b1;
            rep <= 1'b0;
            cnt <= '0;
            pulse <= 1'b0;
        end else begin
            prev <= level;
            armed <= ~level | (armed & ~clear);
            pulse <= activity & ~clear & ((level & ~prev) | hit);
            if (~activity | clear) begin
                cnt <= '0;
                rep <= 1'b0;
            end else if (hit) begin
                cnt <= '0;
                rep <= 1'b1;
            end else if (tick_ms) begin
                cnt <= cnt + W'(1);
            end
        end
    end
endmodule

// File: rtl/clock_set_controller.sv
// clock_set_controller: front-panel set-mode sequencer with INC auto-repeat, idle timeout and blink
module clock_set_controller
    import clock_set_pkg::*;
#(
    parameter int HOLD_MS = HOLD_MS_DEF,
    parameter int REPEAT_MS = REPEAT_MS_DEF,
    parameter int TIMEOUT_MS = TIMEOUT_MS_DEF,
    parameter int BLINK_MS = BLINK_MS_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_ms,
    input  logic btn_mode,
    input  logic btn_inc,
    output logic mode_setcurrent,
    output logic mode_setalarm,
    output logic sel_hour,
    output logic inc_pulse,
    output logic blink
);
    localparam int IW = $clog2(TIMEOUT_MS + 1);
    localparam int BW = $clog2(BLINK_MS + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_MS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);
    set_state_e state, state_d;
    logic mode_prev, mode_rise, in_set, timeout, chg, activity;
    logic [IW-1:0] idle;
    logic [BW-1:0] bcnt;
    btn_repeat #(.HOLD(HOLD_MS), .REPEAT(REPEAT_MS)) u_inc (
        .clk(clk),
        .reset(reset),
        .tick_ms(tick_ms),
        .level(btn_inc),
        .enable(in_set),
        .clear(chg),
        .pulse(inc_pulse),
        .activity(activity)
    );
    always_comb begin
        mode_rise = btn_mode & ~mode_prev;
        in_set = state != RUN;
        timeout = in_set & tick_ms & ~mode_rise & ~activity & (idle == IDLE_LAST);
        chg = mode_rise | timeout;
        state_d = mode_rise ? next_state(state) : timeout ? RUN : state;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            mode_prev <= 1'b0;
            idle <= '0;
            bcnt <= '0;
            blink <= 1'b0;
            mode_setcurrent <= 1'b0;
            mode_setalarm <= 1'b0;
            sel_hour <= 1'b0;
        end else begin
            state <= state_d;
            mode_prev <= btn_mode;
            mode_setcurrent <= state_d inside {SET_CUR_H, SET_CUR_M};
            mode_setalarm <= state_d inside {SET_ALM_H, SET_ALM_M};
            sel_hour <= state_d inside {SET_CUR_H, SET_ALM_H};
            idle <= (~in_set | chg | activity) ? '0 : idle + IW'(tick_ms);
            if (state_d == RUN || chg) begin
                bcnt <= '0;
                blink <= state_d != RUN;
            end else if (tick_ms) begin
                bcnt <= bcnt == BLINK_LAST ? '0 : bcnt + BW'(1);
                blink <= bcnt == BLINK_LAST ? ~blink : blink;
            end
        end
    end
endmodule

// File: tb/tb_clock_set_controller.sv
// tb_clock_set_controller: directed and random stimulus checked against a tick-count reference model
module tb_clock_set_controller;
    localparam int HOLD = 500;
    localparam int REPEAT = 150;
    localparam int TIMEOUT = 10000;
    localparam int BLINK = 250;
    logic clk = 1'b0;
    logic reset, tick_ms, btn_mode, btn_inc;
    logic mode_setcurrent, mode_setalarm, sel_hour, inc_pulse, blink;
    int n_cmp = 0, n_bad = 0, npulse = 0, gap = 0;
    int st, held, idle, bt;
    logic mprev, iprev, armed;
    logic [4:0] exp_o;
    logic [2:0] seq [5] = '{3'b101, 3'b100, 3'b011, 3'b010, 3'b000};
    always #5 clk = ~clk;
    clock_set_controller dut (
        .clk(clk),
        .reset(reset),
        .tick_ms(tick_ms),
        .btn_mode(btn_mode),
        .btn_inc(btn_inc),
        .mode_setcurrent(mode_setcurrent),
        .mode_setalarm(mode_setalarm),
        .sel_hour(sel_hour),
        .inc_pulse(inc_pulse),
        .blink(blink)
    );
    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic int mode_bits();
        return int'({mode_setcurrent, mode_setalarm, sel_hour});
    endfunction
    task automatic model(input logic r, input logic m, input logic i, input logic t);
        logic mr, ir, a, set, to, chg, p;
        if (r) begin
            st = 0; mprev = 0; iprev = 0; armed = 1; held = 0; idle = 0; bt = 0; exp_o = '0;
        end else begin
            mr = m & ~mprev;
            ir = i & ~iprev;
            mprev = m;
            iprev = i;
            a = armed;
            set = st != 0;
            to = set && t && !mr && !(i && a) && idle + 1 == TIMEOUT;
            chg = mr || to;
            p = 0;
            if (set && !chg && i && a) begin
                if (ir) p = 1;
                if (t) begin
                    held++;
                    if (held >= HOLD && (held - HOLD) % REPEAT == 0) p = 1;
                end
            end else held = 0;
            if (!i) armed = 1;
            else if (chg) armed = 0;
            if (!set || chg || (i && a)) idle = 0;
            else if (t) idle++;
            if (mr) st = (st + 1) % 5;
            else if (to) st = 0;
            if (chg) bt = 0;
            else if (t) bt++;
            exp_o = {st == 1 || st == 2, st == 3 || st == 4, st == 1 || st == 3, p,
                     st != 0 && (bt / BLINK) % 2 == 0};
        end
    endtask
    task automatic step(input logic r, input logic m, input logic i, input logic t);
        @(negedge clk);
        reset = r;
        btn_mode = m;
        btn_inc = i;
        tick_ms = t;
        model(r, m, i, t);
        @(posedge clk);
        #1;
        npulse += int'(inc_pulse);
        chk("outs", int'({mode_setcurrent, mode_setalarm, sel_hour, inc_pulse, blink}), int'(exp_o));
    endtask
    task automatic cyc(input logic m, input logic i);
        logic t;
        t = gap == 0;
        gap = t ? int'($urandom_range(1, 0)) : gap - 1;
        step(1'b0, m, i, t);
    endtask
    task automatic ticks(input logic m, input logic i, input int n);
        int k;
        k = 0;
        while (k < n) begin
            k += (gap == 0) ? 1 : 0;
            cyc(m, i);
        end
    endtask
    initial begin
        reset = 1'b1;
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        tick_ms = 1'b0;
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_outs", int'({mode_setcurrent, mode_setalarm, sel_hour, inc_pulse, blink}), 0);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 1'b0);
            chk("mode_seq", mode_bits(), int'(seq[k]));
            cyc(1'b0, 1'b0);
        end
        npulse = 0;
        repeat (3) begin
            cyc(1'b0, 1'b1);
            cyc(1'b0, 1'b1);
            cyc(1'b0, 1'b0);
        end
        ticks(1'b0, 1'b1, 600);
        cyc(1'b0, 1'b0);
        chk("run_no_pulse", npulse, 0);
        chk("run_state", mode_bits(), 0);
        npulse = 0;
        cyc(1'b1, 1'b1);
        chk("same_cycle_state", mode_bits(), 3'b101);
        ticks(1'b0, 1'b1, 1000);
        chk("same_cycle_no_pulse", npulse, 0);
        cyc(1'b0, 1'b0);
        npulse = 0;
        ticks(1'b0, 1'b1, 1000);
        cyc(1'b0, 1'b0);
        chk("hold_pulses", npulse, 5);
        ticks(1'b0, 1'b1, 300);
        cyc(1'b1, 1'b1);
        chk("hold_mode_state", mode_bits(), 3'b100);
        npulse = 0;
        ticks(1'b0, 1'b1, 2000);
        chk("disarmed_no_pulse", npulse, 0);
        cyc(1'b0, 1'b0);
        npulse = 0;
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        chk("rearm_pulse", npulse, 1);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        chk("alm_m_state", mode_bits(), 3'b010);
        ticks(1'b0, 1'b0, TIMEOUT - 1);
        chk("pre_timeout", mode_bits(), 3'b010);
        ticks(1'b0, 1'b0, 1);
        chk("timeout_run", mode_bits(), 0);
        cyc(1'b1, 1'b0);
        ticks(1'b0, 1'b0, TIMEOUT - 2);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        ticks(1'b0, 1'b0, 2);
        chk("inc_defers_timeout", mode_bits(), 3'b101);
        ticks(1'b0, 1'b0, TIMEOUT - 3);
        chk("pre_timeout_after_inc", mode_bits(), 3'b101);
        ticks(1'b0, 1'b0, 1);
        chk("timeout_after_inc", mode_bits(), 0);
        cyc(1'b1, 1'b0);
        npulse = 0;
        ticks(1'b0, 1'b1, 700);
        chk("pre_reset_pulses", npulse, 3);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("reset_mid_hold", int'({mode_setcurrent, mode_setalarm, sel_hour, inc_pulse, blink}), 0);
        npulse = 0;
        ticks(1'b0, 1'b1, 1000);
        chk("post_reset_no_pulse", npulse, 0);
        cyc(1'b0, 1'b0);
        for (int k = 0; k < 6000; k++) begin
            logic m, i;
            m = btn_mode ^ ($urandom_range(39, 0) == 0);
            i = btn_inc ^ ($urandom_range(14, 0) == 0);
            if ($urandom_range(2999, 0) == 0) step(1'b1, m, i, 1'b0);
            else cyc(m, i);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
